// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_STEP    = 4;
    localparam int FETCH_PC_W = 64;  // widest supported PC; narrower PCs are zero-extended

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_fifo.sv
// Circular buffer of fetch entries with synchronous clear; push+pop allowed when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fetch_entry_t           i_din,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [AW-1:0]        r_rd;
    logic [AW-1:0]        r_wr;
    logic [AW:0]          r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop)
                r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head  = (r_cnt != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: PC, FSM, range check, redirect flush and a small fetch FIFO.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  MEM_BYTES = 32,
    parameter int                  BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);

    localparam int                CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [PC_WIDTH:0] LIMIT = (PC_WIDTH + 1)'(MEM_BYTES);
    localparam logic [PC_WIDTH:0] LAST  = (PC_WIDTH + 1)'(3);

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_redir_pc;
    logic                w_in_range;
    logic                w_redir_in_range;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count;
    fetch_entry_t        w_din;
    fetch_entry_t        w_head;

    assign w_redir_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    // Widened by one bit so a wrapped address can never look in range.
    assign w_in_range       = ({1'b0, r_pc} + LAST) < LIMIT;
    assign w_redir_in_range = ({1'b0, w_redir_pc} + LAST) < LIMIT;

    assign w_pop  = if_valid && if_ready;
    assign w_push = (r_state == S_RUN) && w_in_range && !redirect_valid &&
                    ((w_count < CNT_W'(BUF_DEPTH)) || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            if (!w_redir_in_range)
                w_state_nxt = S_HALT;
            else if (r_state != S_IDLE)
                w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_RUN;
                S_RUN:   if (!w_in_range) w_state_nxt = S_HALT;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid)
                r_pc <= w_redir_pc;
            else if (w_push)
                r_pc <= r_pc + PC_WIDTH'(PC_STEP);
        end
    end

    assign w_din.pc    = FETCH_PC_W'(r_pc);
    assign w_din.instr = imem_rdata;

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr = r_pc;
    assign if_valid  = (w_count != '0);
    assign if_instr  = w_head.instr;
    assign if_pc     = PC_WIDTH'(w_head.pc);
    assign halted    = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if ((r_state == S_RUN) && if_valid && !if_ready)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
